// File: rtl/alu_checker.sv
// alu_checker: consumer-side monitor for the alu/aluControl pair.
// It samples each ALU transaction and recomputes the expected result and zero flag.
// It counts checked, mismatching and illegal-code transactions with saturating counters.
// It also captures the first mismatch and can optionally halt after it.
module alu_checker #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic [3:0]       i_control,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_zf,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_checked,
  output logic [CNT_W-1:0] o_errors,
  output logic [CNT_W-1:0] o_illegal,
  output logic             o_err_flag,
  output logic             o_halted,
  output logic [WIDTH-1:0] o_cap_op1,
  output logic [WIDTH-1:0] o_cap_op2,
  output logic [3:0]       o_cap_ctrl,
  output logic [WIDTH-1:0] o_cap_got,
  output logic [WIDTH-1:0] o_cap_exp
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                   state;
  logic                     vld_p0;
  logic signed [WIDTH-1:0]  op1_p0;
  logic signed [WIDTH-1:0]  op2_p0;
  logic [3:0]               ctrl_p0;
  logic [WIDTH-1:0]         res_p0;
  logic                     zf_p0;

  logic [WIDTH-1:0]         exp_p1;
  logic                     legal_p1;
  logic                     zf_exp_p1;
  logic                     mism_p1;

  function automatic logic op_legal(input logic [3:0] ctrl);
    case (ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
      default:                                              op_legal = 1'b0;
    endcase
  endfunction

  // Reference model of the ALU; SLT compares as two's complement because both operands are signed.
  function automatic logic [WIDTH-1:0] alu_ref(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b,
                                               input logic [3:0]              ctrl);
    logic [WIDTH-1:0] r;
    r = '0;
    case (ctrl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1100: r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage 1 data capture; gated by RUN so a halted checker keeps its last sample untouched.
  always_ff @(posedge i_clk) begin
    if (i_valid && (state == RUN)) begin
      op1_p0  <= i_op1;
      op2_p0  <= i_op2;
      ctrl_p0 <= i_control;
      res_p0  <= i_result;
      zf_p0   <= i_zf;
    end
  end

  // Stage 2 expected-value computation and comparison on the stage 1 registers.
  always_comb begin
    exp_p1    = alu_ref(op1_p0, op2_p0, ctrl_p0);
    legal_p1  = op_legal(ctrl_p0);
    zf_exp_p1 = (exp_p1 == '0);
    mism_p1   = (res_p0 != exp_p1) || (zf_p0 != zf_exp_p1);
  end

  // Control: stage valid, FSM, counters and first-mismatch capture; clear overrides everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= RUN;
      vld_p0     <= 1'b0;
      o_checked  <= '0;
      o_errors   <= '0;
      o_illegal  <= '0;
      o_err_flag <= 1'b0;
      o_halted   <= 1'b0;
      o_cap_op1  <= '0;
      o_cap_op2  <= '0;
      o_cap_ctrl <= '0;
      o_cap_got  <= '0;
      o_cap_exp  <= '0;
    end else if (i_clear) begin
      state      <= RUN;
      vld_p0     <= 1'b0;
      o_checked  <= '0;
      o_errors   <= '0;
      o_illegal  <= '0;
      o_err_flag <= 1'b0;
      o_halted   <= 1'b0;
      o_cap_op1  <= '0;
      o_cap_op2  <= '0;
      o_cap_ctrl <= '0;
      o_cap_got  <= '0;
      o_cap_exp  <= '0;
    end else begin
      vld_p0 <= i_valid && (state == RUN);
      if (vld_p0) begin
        if (!legal_p1) begin
          o_illegal <= sat_inc(o_illegal);
        end else begin
          o_checked <= sat_inc(o_checked);
          if (mism_p1) begin
            o_errors <= sat_inc(o_errors);
            if (!o_err_flag) begin
              o_err_flag <= 1'b1;
              o_cap_op1  <= op1_p0;
              o_cap_op2  <= op2_p0;
              o_cap_ctrl <= ctrl_p0;
              o_cap_got  <= res_p0;
              o_cap_exp  <= exp_p1;
            end
            if (STOP_ON_ERR) begin
              state    <= HALT;
              o_halted <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
